// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit arbiter: FSM state encoding and default timing.
package uart_pkg;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;

  localparam int GAP_TICKS_DEF     = 16;
  localparam int TIMEOUT_TICKS_DEF = 1024;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward from last+1, wrapping.
// Zero latency; no grant when req is empty.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IW-1:0]   gnt_idx
);
  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    idx        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (!found && req[idx]) begin
        found           = 1'b1;
        gnt_onehot[idx] = 1'b1;
        gnt_idx         = idx;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter: accepts in IDLE, tx_start one cycle later,
// then waits for tx_done_tick (or tick timeout) and an enforced idle gap before the next accept.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ          = 4,
  parameter int DW            = 32,
  parameter int GAP_TICKS     = GAP_TICKS_DEF,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_tick,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    tx_start,
  output logic [DW-1:0]           tx_din,
  input  logic                    tx_done_tick,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    frame_done,
  output logic                    timeout_err,
  input  logic                    err_clr
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(max_int(TIMEOUT_TICKS, GAP_TICKS) + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST = (GAP_TICKS > 0) ? CW'(GAP_TICKS - 1) : '0;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   hold_q, hold_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic            tx_start_q, tx_start_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic            timeout_err_q, timeout_err_d;
  logic            to_set;
  logic [NREQ-1:0] pick_onehot;
  logic [IW-1:0]   pick_idx;
  logic [DW-1:0]   sel_data;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
    .req        (req_valid),
    .last       (grant_q),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_onehot[i]) sel_data = req_data[i*DW +: DW];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    grant_d      = grant_q;
    tx_start_d   = 1'b0;
    frame_done_d = 1'b0;
    to_set       = 1'b0;
    req_ready    = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          req_ready  = pick_onehot;
          hold_d     = sel_data;
          grant_d    = pick_idx;
          tx_start_d = 1'b1;
          state_d    = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        // A done arriving together with the final timeout tick counts as success.
        if (tx_done_tick) begin
          frame_done_d = 1'b1;
          cnt_d        = '0;
          state_d      = ST_GAP;
        end else if (s_tick) begin
          if (cnt_q == TO_LAST) begin
            to_set  = 1'b1;
            cnt_d   = '0;
            state_d = ST_GAP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        if (GAP_TICKS == 0) begin
          state_d = ST_IDLE;
        end else if (s_tick) begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
    timeout_err_d = to_set ? 1'b1 : (err_clr ? 1'b0 : timeout_err_q);
    busy_d        = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      hold_q        <= '0;
      grant_q       <= IW'(NREQ - 1);
      tx_start_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      grant_q       <= grant_d;
      tx_start_q    <= tx_start_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_din      = hold_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench with requester/transmitter models and a scoreboard monitor for uart_tx_arbiter.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int GAP  = 16;
  localparam int TMO  = 8;

  logic              clk = 1'b0;
  logic              reset, s_tick, err_clr, tx_done_auto, tx_done_stray, tx_done_tick;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*DW-1:0] req_data;
  logic              tx_start, busy, frame_done, timeout_err;
  logic [DW-1:0]     tx_din;
  logic [1:0]        grant_id;

  assign tx_done_tick = tx_done_auto | tx_done_stray;
  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .GAP_TICKS(GAP), .TIMEOUT_TICKS(TMO)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_din(tx_din), .tx_done_tick(tx_done_tick),
    .busy(busy), .grant_id(grant_id), .frame_done(frame_done), .timeout_err(timeout_err),
    .err_clr(err_clr)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stimulus knobs: tick_mode 0=none 1=every cycle 2=random; done_delay<0 means random.
  int tick_mode = 2;
  int done_delay = -1;
  bit auto_en = 1'b1;

  // Requester model: per-requester FIFO of frames, presented until accepted.
  logic [DW-1:0] pend_dat [NREQ][64];
  int head [NREQ] = '{default: 0};
  int tail [NREQ] = '{default: 0};

  task automatic push(input int i, input logic [DW-1:0] d);
    pend_dat[i][tail[i] % 64] = d;
    tail[i]++;
  endtask

  logic [NREQ-1:0] acc;
  initial begin
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready & {NREQ{~reset}};
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) if (acc[i]) head[i]++;
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = (head[i] != tail[i]);
        req_data[i*DW +: DW] = req_valid[i] ? pend_dat[i][head[i] % 64] : '0;
      end
    end
  end

  initial begin
    s_tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (tick_mode)
        0: s_tick = 1'b0;
        1: s_tick = 1'b1;
        default: s_tick = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Transmitter model: answers each tx_start with one tx_done_tick after a delay.
  int tx_d;
  initial begin
    tx_done_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !reset && auto_en) begin
        tx_d = (done_delay < 0) ? int'($urandom_range(0, 5)) : done_delay;
        @(posedge clk); #1;
        repeat (tx_d) begin @(posedge clk); #1; end
        tx_done_auto = 1'b1;
        @(posedge clk); #1;
        tx_done_auto = 1'b0;
      end
    end
  end

  // Reference model state; each flag describes the current cycle.
  typedef struct packed { logic [1:0] id; logic [DW-1:0] dat; } sb_t;
  sb_t exp_q[$];
  sb_t m_e;
  int  grant_log[$];
  bit  rst_prev = 1'b0, clr_prev = 1'b0, prev_busy = 1'b0;
  bit  m_launch = 1'b0, m_wait = 1'b0, m_gap = 1'b0, n_launch, n_wait, n_gap, m_idle;
  bit  exp_err = 1'b0;
  int  m_last = NREQ - 1;
  int  wait_ticks = 0, gap_ticks = 0, exp_fd = -1, exp_to = -1, pick;
  logic [DW-1:0] cur_data = '0, last_start_data = '0;
  logic [NREQ-1:0] exp_rdy;
  int  fd_count = 0, last_fd_cyc = 0, last_idle_cyc = 0, last_start_cyc = 0;

  function automatic int model_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        rst_prev = 1'b1;
        clr_prev = 1'b0;
        continue;
      end
      if (rst_prev) begin
        m_last = NREQ - 1; m_launch = 0; m_wait = 0; m_gap = 0;
        exp_fd = -1; exp_to = -1; exp_err = 0; cur_data = '0; prev_busy = 0;
        exp_q.delete();
        chk("rst_grant_id", grant_id, NREQ - 1);
      end
      if (cyc == exp_to) exp_err = 1'b1;
      else if (clr_prev) exp_err = 1'b0;
      chk("timeout_err", timeout_err, exp_err);
      chk("frame_done", frame_done, cyc == exp_fd);
      chk("busy", busy, m_launch | m_wait | m_gap);
      chk("tx_start_timing", tx_start, m_launch);
      chk("tx_din_hold", tx_din, cur_data);

      if (tx_start) begin
        grant_log.push_back(int'(grant_id));
        last_start_cyc  = cyc;
        last_start_data = tx_din;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL start_unexpected: got id %0d data %0h expected no start", grant_id, tx_din);
        end else begin
          m_e = exp_q.pop_front();
          chk("start_id", grant_id, m_e.id);
          chk("start_dat", tx_din, m_e.dat);
        end
      end
      if (frame_done) begin fd_count++; last_fd_cyc = cyc; end
      if (prev_busy && !busy) last_idle_cyc = cyc;
      prev_busy = busy;

      m_idle = !(m_launch | m_wait | m_gap);
      exp_rdy = '0;
      pick = model_pick(req_valid, m_last);
      if (m_idle && pick >= 0) exp_rdy[pick] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);

      n_launch = 1'b0; n_wait = m_wait; n_gap = m_gap;
      if (m_idle && pick >= 0) begin
        n_launch = 1'b1;
        m_last   = pick;
        cur_data = req_data[pick*DW +: DW];
        exp_q.push_back({2'(pick), cur_data});
      end
      if (m_launch) begin n_wait = 1'b1; wait_ticks = 0; end
      if (m_wait) begin
        if (tx_done_tick) begin
          exp_fd = cyc + 1; n_wait = 0; n_gap = 1; gap_ticks = 0;
        end else if (s_tick) begin
          if (wait_ticks == TMO - 1) begin
            exp_to = cyc + 1; n_wait = 0; n_gap = 1; gap_ticks = 0;
          end else wait_ticks++;
        end
      end
      if (m_gap && s_tick) begin
        gap_ticks++;
        if (gap_ticks == GAP) n_gap = 1'b0;
      end
      m_launch = n_launch; m_wait = n_wait; m_gap = n_gap;
      clr_prev = err_clr;
      rst_prev = 1'b0;
    end
  end

  task automatic wait_quiet(input int budget);
    int n = 0;
    bit empty;
    while (n < budget) begin
      @(negedge clk);
      n++;
      empty = 1'b1;
      for (int i = 0; i < NREQ; i++) if (head[i] != tail[i]) empty = 1'b0;
      if (empty && req_valid == '0 && !busy) break;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_quiet: still busy after %0d cycles, required idle", n);
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  int n, fd_before;
  logic [DW-1:0] dat;

  initial begin
    reset = 1'b1; err_clr = 1'b0; tx_done_stray = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // All four requesters loaded at once: two full rotations.
    grant_log.delete();
    for (int f = 0; f < 2; f++) for (int i = 0; i < NREQ; i++) push(i, $urandom());
    wait_quiet(3000);
    for (int k = 0; k < 8; k++)
      chk($sformatf("fair_order%0d", k), (k < grant_log.size()) ? grant_log[k] : 99, k % 4);

    // Single request from requester 2.
    push(2, 32'hDEADBEEF);
    wait_quiet(1000);
    chk("single_data", last_start_data, 32'hDEADBEEF);
    chk("single_grant", grant_id, 2);

    // Done 5 cycles after tx_start, ticks every cycle.
    tick_mode = 1; done_delay = 4;
    push(1, $urandom());
    wait_quiet(1000);
    chk("done_to_fd", last_fd_cyc - last_start_cyc, 6);
    chk("fd_to_idle", last_idle_cyc - last_fd_cyc, GAP);

    // Timeout without any done.
    tick_mode = 2; done_delay = -1; auto_en = 1'b0;
    fd_before = fd_count;
    push(0, $urandom());
    wait_quiet(1000);
    chk("timeout_set", timeout_err, 1);
    chk("timeout_no_fd", fd_count, fd_before);
    err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("err_clr", timeout_err, 0);

    // Clear held high across a timeout: the set must still be seen for one cycle.
    @(posedge clk); #1;
    tick_mode = 1; err_clr = 1'b1;
    push(3, $urandom());
    wait_quiet(1000);
    err_clr = 1'b0;
    chk("set_wins_then_clear", timeout_err, 0);
    auto_en = 1'b1; tick_mode = 2;

    // Stray done in IDLE.
    fd_before = fd_count;
    tx_done_stray = 1'b1;
    @(posedge clk); #1 tx_done_stray = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_no_fd", fd_count, fd_before);
    chk("stray_idle", busy, 0);
    @(posedge clk); #1;

    // Reset while waiting for done.
    auto_en = 1'b0; tick_mode = 0;
    push(3, $urandom());
    n = 0;
    while (!tx_start && n < 100) begin @(negedge clk); n++; end
    chk("launch_seen", n < 100, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_grant", grant_id, NREQ - 1);
    @(posedge clk); #1;
    auto_en = 1'b1; tick_mode = 2;
    dat = $urandom();
    push(0, dat);
    wait_quiet(1000);
    chk("post_rst_grant", (grant_log.size() > 0) ? grant_log[grant_log.size()-1] : 99, 0);
    chk("post_rst_data", last_start_data, dat);

    // Random traffic with occasional timeouts and clears.
    for (int r = 0; r < 80; r++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0) push($urandom_range(0, NREQ - 1), $urandom());
      auto_en = ($urandom_range(0, 5) != 0);
      err_clr = ($urandom_range(0, 30) == 0);
    end
    err_clr = 1'b0; auto_en = 1'b1;
    wait_quiet(6000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 Parameter DW, default 32: frame data width, matches the UART transmitter DBIT.
REQ-003 Parameter GAP_TICKS, default 16: number of s_tick pulses of enforced idle between frames.
REQ-004 Parameter TIMEOUT_TICKS, default 1024: number of s_tick pulses allowed for a frame without tx_done_tick.
REQ-005 Port clk, input, 1: single clock; all logic is clocked on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port s_tick, input, 1: oversampling tick, the same strobe that feeds the transmitter.
REQ-008 Port req_valid, input, NREQ: per-requester frame request.
REQ-009 Port req_data, input, NREQ*DW: per-requester data; requester i occupies slice [i*DW +: DW].
REQ-010 Port req_ready, output, NREQ: one-hot accept pulse.
REQ-011 Port tx_start, output, 1: start strobe to the transmitter.
REQ-012 Port tx_din, output, DW: data word to the transmitter.
REQ-013 Port tx_done_tick, input, 1: frame-complete pulse from the transmitter.
REQ-014 Port busy, output, 1: high in every state except IDLE.
REQ-015 Port grant_id, output, clog2(NREQ): index of the current or most recent grant.
REQ-016 Port frame_done, output, 1: one-cycle pulse when the granted frame completes.
REQ-017 Port timeout_err, output, 1: sticky flag, set on a frame timeout.
REQ-018 Port err_clr, input, 1: clears timeout_err.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, LAUNCH, WAIT_DONE, GAP.
REQ-020 In IDLE with any req_valid bit high, the block SHALL select the first valid requester searching round-robin from (last_grant+1) mod NREQ.
REQ-021 In that same cycle it SHALL pulse req_ready for the selected requester only, latch its data into a hold register, latch grant_id, and move to LAUNCH.
REQ-022 A transfer SHALL complete only on req_valid & req_ready; a requester may drop req_valid at any time before the accept.
REQ-023 In LAUNCH, tx_start SHALL be high for exactly one cycle, then the FSM SHALL move to WAIT_DONE.
REQ-024 tx_din SHALL equal the hold register and SHALL stay stable from LAUNCH until the FSM returns to IDLE.
REQ-025 In WAIT_DONE, tx_done_tick SHALL pulse frame_done in the next cycle, clear the tick counter, and move the FSM to GAP.
REQ-026 In WAIT_DONE, each s_tick SHALL increment the tick counter.
REQ-027 If the counter reaches TIMEOUT_TICKS-1 on an s_tick without tx_done_tick, the block SHALL set timeout_err, suppress frame_done, and move to GAP.
REQ-028 If tx_done_tick and the timeout condition occur in the same cycle, tx_done_tick SHALL win: no error is flagged.
REQ-029 In GAP, the block SHALL count s_tick pulses and return to IDLE on the s_tick where the count equals GAP_TICKS-1.
REQ-030 If GAP_TICKS=0, GAP SHALL last exactly one cycle.
REQ-031 No request SHALL be accepted outside IDLE; req_ready SHALL be 0 in LAUNCH, WAIT_DONE and GAP.
REQ-032 Round-robin pointer wrap-around: after a grant to NREQ-1, the search SHALL start at 0.
REQ-033 Any tx_done_tick outside WAIT_DONE SHALL be ignored.
REQ-034 err_clr SHALL clear timeout_err; if err_clr and a new timeout occur in the same cycle, the set SHALL win.
REQ-035 The tick counter SHALL be clog2(max(TIMEOUT_TICKS, GAP_TICKS)+1) bits wide, unsigned.

Reset
REQ-036 On reset the block SHALL enter IDLE.
REQ-037 On reset the outputs SHALL be: req_ready=0, tx_start=0, tx_din=0, busy=0, grant_id=NREQ-1 (so the first search starts at 0), frame_done=0, timeout_err=0; the counter and hold register SHALL be 0.
REQ-038 Reset mid-frame SHALL abort the frame immediately, with no frame_done; the transmitter's own reset is the system's responsibility.

Structure
REQ-039 The state encoding localparams and the default GAP_TICKS/TIMEOUT_TICKS values SHALL live in a shared package, uart_pkg.
REQ-040 The round-robin selection SHALL be one combinational sub-module, rr_pick, with inputs req and last and outputs gnt_onehot and gnt_idx.
REQ-041 All outputs except req_ready SHALL be registered.

Verification
REQ-042 Single request: requester 2 asserts with data 0xDEADBEEF -> req_ready[2] pulses, tx_start one cycle later with tx_din=0xDEADBEEF, grant_id=2.
REQ-043 Fairness: all four requesters held valid for 8 frames -> grant order 0,1,2,3,0,1,2,3.
REQ-044 Timing: tx_done_tick returned 5 cycles after tx_start -> frame_done one cycle later, then busy low exactly 16 s_ticks later (GAP_TICKS=16).
REQ-045 Timeout: TIMEOUT_TICKS=8 and no tx_done_tick -> timeout_err set after 8 s_ticks, no frame_done.
REQ-046 Error clear: err_clr asserted after a timeout -> timeout_err=0 on the next cycle.
REQ-047 Reset in WAIT_DONE: reset asserted during WAIT_DONE -> next cycle busy=0, tx_start=0, grant_id=NREQ-1; the next request, from requester 0, is granted.
REQ-048 Stray done: tx_done_tick pulsed in IDLE -> no frame_done and no state change.
